// File: rtl/seq_mult_param.sv
// seq_mult_param: sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed operands are multiplied as magnitudes, and the sign is applied on the way out.
// Ports:
//   clk, rst (sync, active-high)
//   start, signed_mode, a, b : request and operands, latched on accept
//   d_out      : product, held until the next accepted start
//   done_flag  : one-cycle pulse marking a valid d_out
//   busy       : high while calculating
module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] d_out,
    output logic               done_flag,
    output logic               busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic               neg_res;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_in;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_next;
    logic               last;

    // The absolute value of the most negative operand still fits as an unsigned WIDTH-bit magnitude.
    always_comb begin
        mag_a  = (signed_mode && a[WIDTH-1]) ? -a : a;
        mag_b  = (signed_mode && b[WIDTH-1]) ? -b : b;
        neg_in = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    // The final partial product is folded straight into d_out on the edge that enters DONE.
    always_comb begin
        addend   = '0;
        if (mplier[0]) begin
            addend = {{WIDTH{1'b0}}, mcand} << cnt;
        end
        acc_next = acc + addend;
        last     = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            acc       <= '0;
            neg_res   <= 1'b0;
            d_out     <= '0;
            done_flag <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done_flag <= 1'b0;
                    if (start) begin
                        mcand   <= mag_a;
                        mplier  <= mag_b;
                        neg_res <= neg_in;
                        acc     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end else begin
                        state   <= IDLE;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        d_out     <= neg_res ? -acc_next : acc_next;
                        done_flag <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed checks of seq_mult_param at WIDTH=8 and WIDTH=16.
// Covers latency, busy timing, signed/unsigned products, back-to-back operation and mid-calculation reset.
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic [15:0] d_out8;
    logic        done8, busy8;

    logic        start16, sm16;
    logic [15:0] a16, b16;
    logic [31:0] d_out16;
    logic        done16, busy16;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .d_out(d_out8), .done_flag(done8), .busy(busy8)
    );

    seq_mult_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .d_out(d_out16), .done_flag(done16), .busy(busy16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation from idle; a/b/signed_mode are scrambled and start is pulsed mid-calculation.
    task automatic op8(input string tag, input logic sm, input logic [7:0] x,
                       input logic [7:0] y, input logic [15:0] exp);
        int lat;
        int bcnt;
        sm8 = sm; a8 = x; b8 = y; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm;
        lat = 0; bcnt = 0;
        while (!done8 && lat < 20) begin
            if (busy8) bcnt++;
            tick();
            lat++;
            start8 = (lat == 3);
        end
        start8 = 1'b0;
        chk({tag, " latency"}, 64'(lat), 64'd8);
        chk({tag, " product"}, 64'(d_out8), 64'(exp));
        chk({tag, " busy_cycles"}, 64'(bcnt), 64'd8);
        chk({tag, " busy_at_done"}, 64'(busy8), 64'd0);
        tick();
        chk({tag, " done_pulse"}, 64'(done8), 64'd0);
        chk({tag, " held"}, 64'(d_out8), 64'(exp));
    endtask

    task automatic op16(input string tag, input logic sm, input logic [15:0] x,
                        input logic [15:0] y, input logic [31:0] exp);
        int lat;
        sm16 = sm; a16 = x; b16 = y; start16 = 1'b1;
        tick();
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 0;
        while (!done16 && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'd16);
        chk({tag, " product"}, 64'(d_out16), 64'(exp));
        tick();
    endtask

    initial begin
        logic [7:0]  rx, ry;
        logic [15:0] rexp;
        int          gap;
        int          seen;

        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        tick();
        tick();
        chk("reset d_out8", 64'(d_out8), 64'd0);
        chk("reset done8", 64'(done8), 64'd0);
        chk("reset busy8", 64'(busy8), 64'd0);
        chk("reset d_out16", 64'(d_out16), 64'd0);
        rst = 1'b0;
        tick();

        op8("u81x13", 1'b0, 8'h81, 8'h13, 16'h0993);
        op8("uF0x35", 1'b0, 8'hF0, 8'h35, 16'h31B0);
        op8("sF0x35", 1'b1, 8'hF0, 8'h35, 16'hFCB0);
        op8("uFFxF1", 1'b0, 8'hFF, 8'hF1, 16'hF00F);
        op8("sFFxF1", 1'b1, 8'hFF, 8'hF1, 16'h000F);
        op8("s80x80", 1'b1, 8'h80, 8'h80, 16'h4000);
        op8("uFFx00", 1'b0, 8'hFF, 8'h00, 16'h0000);
        op8("sFFx00", 1'b1, 8'hFF, 8'h00, 16'h0000);
        op8("s7Fx80", 1'b1, 8'h7F, 8'h80, 16'hC080);
        op8("uFFxFF", 1'b0, 8'hFF, 8'hFF, 16'hFE01);

        for (int i = 0; i < 16; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            if (i[0]) rexp = 16'($signed({{8{rx[7]}}, rx}) * $signed({{8{ry[7]}}, ry}));
            else      rexp = 16'({8'd0, rx} * {8'd0, ry});
            op8($sformatf("rand%0d", i), i[0], rx, ry, rexp);
        end

        // Back-to-back: start held high, second operands presented while the first runs.
        sm8 = 1'b0; a8 = 8'hAB; b8 = 8'hCD; start8 = 1'b1;
        tick();
        a8 = 8'h11; b8 = 8'h11;
        seen = 0;
        while (!done8 && seen < 20) begin
            tick();
            seen++;
        end
        chk("b2b first latency", 64'(seen), 64'd8);
        chk("b2b first product", 64'(d_out8), 64'h88EF);
        gap = 0;
        tick();
        gap++;
        while (!done8 && gap < 20) begin
            tick();
            gap++;
        end
        start8 = 1'b0;
        chk("b2b gap", 64'(gap), 64'd9);
        chk("b2b second product", 64'(d_out8), 64'h0121);
        tick();
        tick();

        // Reset during the fourth calculation cycle discards the result.
        sm8 = 1'b0; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset d_out", 64'(d_out8), 64'd0);
        chk("midreset done", 64'(done8), 64'd0);
        chk("midreset busy", 64'(busy8), 64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) seen++;
            tick();
        end
        chk("midreset no done", 64'(seen), 64'd0);
        op8("after reset", 1'b0, 8'h12, 8'h34, 16'h03A8);

        op16("u16 FFFFxFFFF", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        op16("s16 8000x8000", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
        op16("s16 FFFEx0003", 1'b1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA);
        op16("u16 1234x5678", 1'b0, 16'h1234, 16'h5678, 32'h06260060);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult_param.md
# seq_mult_param

Parametrised sequential shift-add multiplier, successor to the fixed 8x8 multiplier behind `top`. It accepts two WIDTH-bit operands on a `start` pulse and produces a 2*WIDTH-bit product after WIDTH calculation cycles, one partial product per cycle. It adds a per-operation signed/unsigned mode, a `busy` status output and back-to-back operation. It sits between operand registers and the display/result path, replacing the fixed-width core.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when it can be accepted (IDLE or DONE).
- `signed_mode`  in  1  0 = unsigned operands, 1 = two's-complement operands; latched with `start`.
- `a`  in  WIDTH  multiplicand; latched with `start`.
- `b`  in  WIDTH  multiplier; latched with `start`.
- `d_out`  out  2*WIDTH  product; valid when `done`=1, held until the next accepted `start`.
- `done_flag`  out  1  one-cycle pulse marking valid `d_out`.
- `busy`  out  1  high while in CALC.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: `start`=1 latches `a`, `b`, `signed_mode`; clears accumulator and bit counter; goes to CALC. `start`=0 stays in IDLE.
- Operand prep at latch:
  - Unsigned: magnitudes are the raw operands.
  - Signed: magnitude = two's-complement absolute value, held as an unsigned WIDTH-bit value (e.g. -2^(WIDTH-1) gives 2^(WIDTH-1)).
  - `neg_res` = sign(a) XOR sign(b) when signed, else 0.
- CALC: each cycle, if multiplier LSB = 1, add the multiplicand, shifted by the counter, into the 2*WIDTH accumulator. Then shift the multiplier right and increment the counter. After exactly WIDTH CALC cycles, go to DONE.
- DONE: `d_out` = `neg_res` ? -acc : acc, truncated to 2*WIDTH bits. `done_flag`=1 for this cycle only.
  - `start`=1 in DONE is accepted as in IDLE and goes straight to CALC.
  - Otherwise go to IDLE.
- `start` in CALC is ignored; no queuing.
- Inputs `a`, `b`, `signed_mode` may change freely after the latch edge without effect.
- Arithmetic: the result is exact for all operand pairs in both modes. The 2*WIDTH product never overflows, including (-2^(WIDTH-1))^2 = 2^(2WIDTH-2).
- Reset (any state, including mid-CALC): next state IDLE, `d_out`=0, `done_flag`=0, `busy`=0. Accumulator, counter and operand registers are cleared. The in-flight result is discarded and no `done_flag` is issued for it.

## Timing
- Accept at edge k → CALC during cycles k+1..k+WIDTH; `busy`=1 after edges k..k+WIDTH-1.
- After edge k+WIDTH: DONE, `done_flag`=1, `d_out` valid, `busy`=0.
- Latency: start edge to done edge = WIDTH cycles.
- Throughput: one result per WIDTH+1 cycles with `start` held high; WIDTH+2 cycles when passing through IDLE.
- `d_out` changes only on the edge that enters DONE, or on reset.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- WIDTH=8, unsigned, a=0x81, b=0x13 → `done_flag` 8 cycles after start, `d_out`=0x0993. `busy` high exactly 8 cycles.
- WIDTH=8, a=0xF0, b=0x35: unsigned → 0x31B0; signed → 0xFCB0 (-848).
- WIDTH=8, a=0xFF, b=0xF1: unsigned → 0xF00F; signed → 0x000F. Also a=0x80, b=0x80 signed → 0x4000. Also a=0xFF, b=0x00 → 0x0000 in both modes.
- Back-to-back: hold `start`=1 with a=0xAB, b=0xCD then a=0x11, b=0x11 → results 0x88EF and 0x0121, 9 cycles apart. Toggling a/b/`start` during CALC has no effect.
- Reset at CALC cycle 4 → next cycle IDLE, all outputs 0, no `done_flag`. A new start then completes normally.
- WIDTH=16 instance, unsigned: 0xFFFF*0xFFFF → 0xFFFE0001, latency 16. Random compare against a reference model, 1000 ops per mode.
